// File: rtl/spi_ecc_pkg.sv
// Shared SECDED constants and helpers for the SPI link (16-bit extended Hamming).
// Packet bit index equals Hamming position; bit 0 carries overall even parity.
package spi_ecc_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned PKT_W  = 16;
    localparam int unsigned SYN_W  = 4;

    // Hamming position of data bit d[i]; entry 0 is the rightmost element.
    localparam logic [DATA_W-1:0][SYN_W-1:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    // XOR of the indices of the set bits among positions 1..15.
    function automatic logic [SYN_W-1:0] syndrome(input logic [PKT_W-1:0] pkt);
        return {^(pkt & 16'hFF00), ^(pkt & 16'hF0F0),
                ^(pkt & 16'hCCCC), ^(pkt & 16'hAAAA)};
    endfunction

    // Build a full SECDED packet from an 11-bit payload.
    function automatic logic [PKT_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [PKT_W-1:0] p;
        logic [SYN_W-1:0] s;
        p = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            p[DATA_POS[4'(i)]] = d[4'(i)];
        end
        // With parity positions still zero, the syndrome is exactly the parity needed.
        s    = syndrome(p);
        p[1] = s[0];
        p[2] = s[1];
        p[4] = s[2];
        p[8] = s[3];
        p[0] = ^p[PKT_W-1:1];
        return p;
    endfunction

    // Pull the payload out of a packet without any correction.
    function automatic logic [DATA_W-1:0] extract(input logic [PKT_W-1:0] pkt);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            d[4'(i)] = pkt[DATA_POS[4'(i)]];
        end
        return d;
    endfunction

endpackage

// File: rtl/spi_slave_secded_dec.sv
// Combinational SECDED decoder: packet -> {data, single_err, double_err}.
// SPI_SLAVE_CORRECT_EN defined: single errors are corrected.
// SPI_SLAVE_CORRECT_EN undefined: detect-only, any error is flagged as double.
module spi_slave_secded_dec
    import spi_ecc_pkg::*;
(
    input  logic [PKT_W-1:0]  i_pkt,
    output logic [DATA_W-1:0] o_data_c,
    output logic              o_single_err_c,
    output logic              o_double_err_c
);

    logic [SYN_W-1:0] w_syn;
    logic             w_par;

    assign w_syn = syndrome(i_pkt);
    assign w_par = ^i_pkt;

`ifdef SPI_SLAVE_CORRECT_EN
    logic [PKT_W-1:0] w_flip;

    // Odd overall parity means one bad bit at the syndrome position (0 means bit 0).
    always_comb begin
        w_flip = '0;
        if (w_par) begin
            w_flip = PKT_W'(1) << w_syn;
        end
    end

    assign o_data_c       = extract(i_pkt ^ w_flip);
    assign o_single_err_c = w_par;
    assign o_double_err_c = !w_par && (w_syn != '0);
`else
    // Detect-only: never trust a correction, report any inconsistency as fatal.
    assign o_data_c       = extract(i_pkt);
    assign o_single_err_c = 1'b0;
    assign o_double_err_c = w_par || (w_syn != '0);
`endif

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint for the SECDED link: receives a 16-bit packet per ss frame,
// decodes it, and shifts an encoded response back on msg_out in the same frame.
// Build option: define SPI_SLAVE_CORRECT_EN to enable single-error correction.
module spi_slave
    import spi_ecc_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic              ss,
    input  logic              msg_in,
    output logic              msg_out,
    input  logic [DATA_W-1:0] data_from_proc,
    output logic [DATA_W-1:0] data_to_proc,
    output logic              rx_valid,
    output logic              single_err,
    output logic              double_err,
    output logic              frame_abort
);

    localparam logic [SYN_W-1:0] CNT_LAST = 4'd15;

    logic [SYN_W-1:0]  r_cnt;
    // Only 15 bits are stored: the 16th packet bit is msg_in itself at decode time.
    logic [PKT_W-2:0]  r_rx_sr;
    logic [PKT_W-1:0]  r_tx_sr;
    logic [DATA_W-1:0] r_data;
    logic              r_rx_valid;
    logic              r_single_err;
    logic              r_double_err;
    logic              r_frame_abort;

    logic              w_last;
    logic              w_abort;
    logic [PKT_W-1:0]  w_pkt;
    logic [PKT_W-1:0]  w_tx_load;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_dec_single;
    logic              w_dec_double;

    assign w_last    = ss && (r_cnt == CNT_LAST);
    assign w_abort   = !ss && (r_cnt != '0);
    assign w_pkt     = {r_rx_sr, msg_in};
    assign w_tx_load = encode(data_from_proc);

    spi_slave_secded_dec u_dec (
        .i_pkt          (w_pkt),
        .o_data_c       (w_dec_data),
        .o_single_err_c (w_dec_single),
        .o_double_err_c (w_dec_double)
    );

    // Frame counter: runs while selected, wraps for back-to-back frames, idles at 0.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (ss) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // RX shift register; a partial packet is dropped on abort.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_rx_sr <= '0;
        end else if (ss) begin
            r_rx_sr <= {r_rx_sr[PKT_W-3:0], msg_in};
        end else if (w_abort) begin
            r_rx_sr <= '0;
        end
    end

    // TX shift register: preload while idle and at frame end, shift while selected.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tx_sr <= '0;
        end else if (!ss || w_last) begin
            r_tx_sr <= w_tx_load;
        end else begin
            r_tx_sr <= {r_tx_sr[PKT_W-2:0], 1'b0};
        end
    end

    // Capture decoded payload and flags on the 16th bit; they hold until the next frame.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_data       <= '0;
            r_single_err <= 1'b0;
            r_double_err <= 1'b0;
        end else if (w_last) begin
            r_data       <= w_dec_data;
            r_single_err <= w_dec_single;
            r_double_err <= w_dec_double;
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_rx_valid    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= w_last;
            r_frame_abort <= w_abort;
        end
    end

    assign msg_out      = ss & r_tx_sr[PKT_W-1];
    assign data_to_proc = r_data;
    assign rx_valid     = r_rx_valid;
    assign single_err   = r_single_err;
    assign double_err   = r_double_err;
    assign frame_abort  = r_frame_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_spi_slave;

    logic        clk_in;
    logic        reset;
    logic        ss;
    logic        msg_in;
    logic        msg_out;
    logic [10:0] data_from_proc;
    logic [10:0] data_to_proc;
    logic        rx_valid;
    logic        single_err;
    logic        double_err;
    logic        frame_abort;

    int          n_checks;
    int          n_errors;
    int          n_abort;
    logic [12:0] rxq[$];   // {double_err, single_err, data} per rx_valid pulse

    spi_slave dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .ss             (ss),
        .msg_in         (msg_in),
        .msg_out        (msg_out),
        .data_from_proc (data_from_proc),
        .data_to_proc   (data_to_proc),
        .rx_valid       (rx_valid),
        .single_err     (single_err),
        .double_err     (double_err),
        .frame_abort    (frame_abort)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Record every delivered frame and every abort pulse.
    always @(negedge clk_in) begin
        if (rx_valid) rxq.push_back({double_err, single_err, data_to_proc});
        if (frame_abort) n_abort++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive nbits of pkt MSB first with ss high; collect msg_out bits.
    task automatic frame(input logic [15:0] pkt, input int nbits,
                         input logic [10:0] next_resp, output logic [15:0] tx);
        tx = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_in);
            ss     = 1'b1;
            msg_in = pkt[15-i];
            if (i == 1) data_from_proc = next_resp;
            #1;
            tx[15-i] = msg_out;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            ss     = 1'b0;
            msg_in = 1'b0;
        end
        #1;
    endtask

    // Pop the oldest delivered frame and compare it with the expectation.
    task automatic expect_rx(input string tag, input logic [10:0] d, input logic se, input logic de);
        logic [12:0] r;
        r = 'x;
        if (rxq.size() > 0) r = rxq.pop_front();
        check_eq(tag, 32'(r), 32'({de, se, d}));
    endtask

    logic [15:0] tx;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        n_abort        = 0;
        reset          = 1'b1;
        ss             = 1'b0;
        msg_in         = 1'b0;
        data_from_proc = 11'h000;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        #1;

        // Reset state
        check_eq("rst_data", 32'(data_to_proc), 32'h0);
        check_eq("rst_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_serr", 32'(single_err), 32'h0);
        check_eq("rst_derr", 32'(double_err), 32'h0);
        check_eq("rst_abort", 32'(frame_abort), 32'h0);
        check_eq("rst_msg_out", 32'(msg_out), 32'h0);

        // Clean frame 000F, response 7FF; then back-to-back FFBF with response 001
        data_from_proc = 11'h7FF;
        idle(2);
        frame(16'h000F, 16, 11'h001, tx);
        check_eq("tx_7ff", 32'(tx), 32'hFFFF);
        frame(16'hFFBF, 16, 11'h000, tx);
        check_eq("tx_001_b2b", 32'(tx), 32'h000F);
        @(negedge clk_in);
        ss = 1'b0;
        #1;
        check_eq("valid_pulse", 32'(rx_valid), 32'h1);
        @(negedge clk_in);
        #1;
        check_eq("valid_drop", 32'(rx_valid), 32'h0);
        check_eq("b2b_count", 32'(rxq.size()), 32'h2);
        expect_rx("rx_clean_000f", 11'h001, 1'b0, 1'b0);
`ifdef SPI_SLAVE_CORRECT_EN
        expect_rx("rx_single_ffbf", 11'h7FF, 1'b1, 1'b0);
`else
        expect_rx("rx_single_ffbf", 11'h7FB, 1'b0, 1'b1);
`endif

        // Double error
        idle(2);
        frame(16'h0009, 16, 11'h000, tx);
        idle(2);
        check_eq("dbl_count", 32'(rxq.size()), 32'h1);
        expect_rx("rx_double_0009", 11'h001, 1'b0, 1'b1);
        check_eq("dbl_flags_hold", 32'({double_err, single_err}), 32'h2);

        // Abort at cnt=7
        frame(16'hFFFF, 7, 11'h7FF, tx);
        @(negedge clk_in);
        ss = 1'b0;
        @(negedge clk_in);
        #1;
        check_eq("abort_pulse", 32'(frame_abort), 32'h1);
        check_eq("abort_no_valid", 32'(rx_valid), 32'h0);
        check_eq("abort_data_hold", 32'(data_to_proc), 32'h001);
        check_eq("abort_flags_hold", 32'(double_err), 32'h1);
        @(negedge clk_in);
        #1;
        check_eq("abort_drop", 32'(frame_abort), 32'h0);
        check_eq("abort_rxq", 32'(rxq.size()), 32'h0);
        frame(16'hFFFF, 16, 11'h7FF, tx);
        idle(2);
        expect_rx("rx_after_abort", 11'h7FF, 1'b0, 1'b0);
        check_eq("abort_count", 32'(n_abort), 32'h1);

        // Reset at cnt=10
        frame(16'h0009, 10, 11'h7FF, tx);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        #1;
        check_eq("mid_rst_outs",
                 32'({data_to_proc, rx_valid, single_err, double_err, frame_abort, msg_out}),
                 32'h0);
        reset = 1'b0;
        ss    = 1'b0;
        idle(3);
        check_eq("mid_rst_no_valid", 32'(rxq.size()), 32'h0);
        check_eq("mid_rst_no_abort", 32'(n_abort), 32'h1);
        frame(16'h000F, 16, 11'h7FF, tx);
        check_eq("tx_after_rst", 32'(tx), 32'hFFFF);
        idle(2);
        expect_rx("rx_after_rst", 11'h001, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
